// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;

  localparam logic [INST_W-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fifoEntryT;

  // Pick the 32-bit word out of a returned doubleword using PC bit 2.
  function automatic logic [INST_W-1:0] selectWord(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with clear; DEPTH must be a power of two.
// Push while full is only honoured when a pop happens in the same cycle.
module ifu_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           headData,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  // Pointers and occupancy; clear discards everything and wins over push/pop.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage array needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues credit-limited
// sequential fetches, buffers responses and hands instructions to IF/ID.
// Build option IFU_BYPASS_EN: a response arriving at an empty buffer is
// forwarded to the pipeline in the same cycle instead of waiting a cycle.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RedirectValid,
  input  logic [63:0]       RedirectAddr,
  output logic              ReqValid,
  input  logic              ReqReady,
  output logic [63:0]       ReqAddr,
  input  logic              RespValid,
  input  logic [63:0]       RespData,
  output logic              InstValid,
  input  logic              InstReady,
  output logic [31:0]       InstOut,
  output logic [63:0]       InstAddrOut
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = FIFO_DEPTH[CW:0];

  logic              runFlag;
  logic [ADDR_W-1:0] fetchPc;
  logic [CW-1:0]     outCnt;
  logic [CW-1:0]     dropCnt;
  logic [CW:0]       creditUsed;
  logic              reqFire;
  logic              respTake;
  logic              respDrop;
  logic              bypassHit;
  logic              instPush;
  logic              instPop;
  logic [INST_W-1:0] respWord;
  fifoEntryT         instIn;
  fifoEntryT         instHead;
  logic [CW-1:0]     instCount;
  logic              instFull;
  logic              instEmpty;
  logic [ADDR_W-1:0] tagHead;
  logic [CW-1:0]     tagCount;
  logic              tagFull;
  logic              tagEmpty;
  logic              unusedBits;

  // Responses still owed for dropped requests keep holding their credit.
  assign creditUsed = {1'b0, outCnt} + {1'b0, instCount};
  assign ReqValid   = runFlag && !RedirectValid && (creditUsed < CREDITS);
  assign ReqAddr    = {fetchPc[63:3], 3'b000};
  assign reqFire    = ReqValid && ReqReady;

  assign respTake = RespValid && !RedirectValid && (dropCnt == '0);
  assign respDrop = RespValid && !RedirectValid && (dropCnt != '0);
  assign respWord = selectWord(RespData, tagHead[2]);
  assign instIn   = '{addr: tagHead, inst: respWord};

`ifdef IFU_BYPASS_EN
  assign bypassHit = respTake && instEmpty;
`else
  assign bypassHit = 1'b0;
`endif

  assign instPush = respTake && !(bypassHit && InstReady);
  assign instPop  = !RedirectValid && InstReady && !instEmpty;

  assign unusedBits = ^{tagCount, tagFull, tagEmpty, instFull, RedirectAddr[1:0]};

  // Fetch PC, outstanding-response count and post-redirect discard count.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      runFlag <= 1'b0;
      fetchPc <= RESET_PC;
      outCnt  <= '0;
      dropCnt <= '0;
    end else begin
      runFlag <= 1'b1;
      outCnt  <= outCnt + CW'(reqFire) - CW'(RespValid);
      if (RedirectValid) begin
        fetchPc <= {RedirectAddr[63:2], 2'b00};
        dropCnt <= outCnt - CW'(RespValid);
      end else begin
        if (reqFire)  fetchPc <= fetchPc + 64'd4;
        if (respDrop) dropCnt <= dropCnt - CW'(1);
      end
    end
  end

  // Present the buffer head, or the arriving word when bypassing an empty buffer.
  always_comb begin
    InstValid   = 1'b0;
    InstOut     = INST_NOP;
    InstAddrOut = '0;
    if (!instEmpty) begin
      InstValid   = 1'b1;
      InstOut     = instHead.inst;
      InstAddrOut = instHead.addr;
    end else if (bypassHit) begin
      InstValid   = 1'b1;
      InstOut     = respWord;
      InstAddrOut = tagHead;
    end
  end

  ifu_fifo #(.WIDTH($bits(fifoEntryT)), .DEPTH(FIFO_DEPTH)) instBuf (
    .clk      (Clk),
    .rstN     (Rst),
    .clear    (RedirectValid),
    .push     (instPush),
    .pushData (instIn),
    .pop      (instPop),
    .headData (instHead),
    .count    (instCount),
    .full     (instFull),
    .empty    (instEmpty)
  );

  ifu_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) tagQueue (
    .clk      (Clk),
    .rstN     (Rst),
    .clear    (RedirectValid),
    .push     (reqFire),
    .pushData (fetchPc),
    .pop      (respTake),
    .headData (tagHead),
    .count    (tagCount),
    .full     (tagFull),
    .empty    (tagEmpty)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a small in-order memory model.
module tb_inst_fetch_unit;
  import ifu_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        RedirectValid = 1'b0;
  logic [63:0] RedirectAddr = '0;
  logic        ReqValid;
  logic        ReqReady = 1'b0;
  logic [63:0] ReqAddr;
  logic        RespValid = 1'b0;
  logic [63:0] RespData = '0;
  logic        InstValid;
  logic        InstReady = 1'b0;
  logic [31:0] InstOut;
  logic [63:0] InstAddrOut;

  inst_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .RedirectValid(RedirectValid), .RedirectAddr(RedirectAddr),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .RespValid(RespValid), .RespData(RespData),
    .InstValid(InstValid), .InstReady(InstReady), .InstOut(InstOut), .InstAddrOut(InstAddrOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } memReqT;

  typedef struct {
    logic        redir;
    logic [63:0] raddr;
    logic        rr;
    logic        ir;
    logic        expReqValid;
    logic [63:0] expReqAddr;
    logic        expInstValid;
    logic [63:0] expInstAddr;
  } vecT;

  memReqT      memQ[$];
  vecT         tbl[7];
  int          nVec = 0;
  int          nMis = 0;
  int          cyc = 0;
  int          memLat = 1;
  int          nReq = 0;
  int          nCons = 0;
  logic [63:0] reqPc = RPC;
  logic [63:0] expPc = RPC;
  logic        sReqValid;
  logic        sInstValid;
  logic [63:0] sReqAddr;
  logic [63:0] sInstAddr;
  logic [31:0] sInst;

  function automatic logic [31:0] wordOf(input logic [63:0] pc);
    return (pc[31:0] << 5) | 32'h13;
  endfunction

  function automatic logic [63:0] memData(input logic [63:0] a);
    return {wordOf(a + 64'd4), wordOf(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setVec(input int i, input logic rv, input logic [63:0] ra,
                        input logic iv, input logic [63:0] ia);
    tbl[i] = '{1'b0, 64'h0, 1'b1, 1'b1, rv, ra, iv, ia};
  endtask

  // One clock: drive inputs on the falling edge, sample 1ns later, update models.
  task automatic cycle(input logic redir, input logic [63:0] raddr, input logic rr,
                       input logic ir, input logic autoRedir, output logic fired);
    logic respNow;
    @(negedge Clk);
    respNow = (memQ.size() > 0) && (memQ[0].due <= cyc);
    if (autoRedir && respNow && memQ.size() == 1) begin
`ifdef IFU_BYPASS_EN
      redir = 1'b1;
`else
      redir = InstValid;
`endif
    end
    fired = redir;
    RedirectValid = redir;
    RedirectAddr  = raddr;
    ReqReady      = rr;
    InstReady     = ir;
    RespValid     = respNow;
    RespData      = respNow ? memData(memQ[0].addr) : 64'h0;
    if (respNow) void'(memQ.pop_front());
    #1;
    sReqValid  = ReqValid;
    sReqAddr   = ReqAddr;
    sInstValid = InstValid;
    sInstAddr  = InstAddrOut;
    sInst      = InstOut;
    if (sReqValid) chk("req_addr", sReqAddr, {reqPc[63:3], 3'b000});
    if (!sInstValid) begin
      chk("idle_inst", {32'h0, sInst}, {32'h0, INST_NOP});
      chk("idle_addr", sInstAddr, 64'h0);
    end
    if (redir) begin
      chk("redir_req_valid", {63'h0, sReqValid}, 64'h0);
      reqPc = {raddr[63:2], 2'b00};
      expPc = {raddr[63:2], 2'b00};
    end else begin
      if (sReqValid && rr) begin
        memQ.push_back('{sReqAddr, cyc + memLat});
        reqPc = reqPc + 64'd4;
        nReq++;
      end
      if (sInstValid && ir) begin
        chk("consume_addr", sInstAddr, expPc);
        chk("consume_inst", {32'h0, sInst}, {32'h0, wordOf(expPc)});
        expPc = expPc + 64'd4;
        nCons++;
      end
    end
    cyc++;
  endtask

  task automatic doReset();
    @(negedge Clk);
    Rst = 1'b0;
    RedirectValid = 1'b0;
    ReqReady = 1'b0;
    InstReady = 1'b0;
    RespValid = 1'b0;
    memQ.delete();
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_req_valid", {63'h0, ReqValid}, 64'h0);
    chk("rst_req_addr", ReqAddr, {RPC[63:3], 3'b000});
    chk("rst_inst_valid", {63'h0, InstValid}, 64'h0);
    chk("rst_inst", {32'h0, InstOut}, {32'h0, INST_NOP});
    chk("rst_inst_addr", InstAddrOut, 64'h0);
    reqPc = RPC;
    expPc = RPC;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fired;
    logic seen;
    int   n0;

`ifdef IFU_BYPASS_EN
    setVec(0, 1'b1, 64'h8000_0000, 1'b0, 64'h0);
    setVec(1, 1'b1, 64'h8000_0000, 1'b1, 64'h8000_0000);
    setVec(2, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004);
    setVec(3, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0008);
    setVec(4, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_000C);
    setVec(5, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0010);
    setVec(6, 1'b1, 64'h8000_0018, 1'b1, 64'h8000_0014);
`else
    setVec(0, 1'b1, 64'h8000_0000, 1'b0, 64'h0);
    setVec(1, 1'b1, 64'h8000_0000, 1'b0, 64'h0);
    setVec(2, 1'b0, 64'h0,         1'b1, 64'h8000_0000);
    setVec(3, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004);
    setVec(4, 1'b1, 64'h8000_0008, 1'b0, 64'h0);
    setVec(5, 1'b0, 64'h0,         1'b1, 64'h8000_0008);
    setVec(6, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_000C);
`endif

    doReset();

    // streaming from reset with a 1-cycle memory
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].redir, tbl[i].raddr, tbl[i].rr, tbl[i].ir, 1'b0, fired);
      chk("tbl_req_valid", {63'h0, sReqValid}, {63'h0, tbl[i].expReqValid});
      if (tbl[i].expReqValid) chk("tbl_req_addr", sReqAddr, tbl[i].expReqAddr);
      chk("tbl_inst_valid", {63'h0, sInstValid}, {63'h0, tbl[i].expInstValid});
      if (tbl[i].expInstValid) begin
        chk("tbl_inst_addr", sInstAddr, tbl[i].expInstAddr);
        chk("tbl_inst", {32'h0, sInst}, {32'h0, wordOf(tbl[i].expInstAddr)});
      end
    end

    // reset mid-stream, then stall the pipeline
    doReset();
    n0 = nReq;
    for (int i = 0; i < 10; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, fired);
    chk("stall_req_count", 64'(nReq - n0), 64'(DEPTH));
    chk("stall_req_valid", {63'h0, sReqValid}, 64'h0);
    chk("stall_inst_valid", {63'h0, sInstValid}, 64'h1);
    chk("stall_head_addr", sInstAddr, RPC);
    n0 = nCons;
    for (int i = 0; i < 12; i++) cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);
    chk("drain_progress", {63'h0, (nCons - n0) >= 4}, 64'h1);

    // memory back-pressure: request must hold steady
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, fired);
      seen = sReqValid;
    end
    chk("hold_req_seen", {63'h0, seen}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, fired);
      chk("hold_req_valid", {63'h0, sReqValid}, 64'h1);
      chk("hold_req_addr", sReqAddr, {reqPc[63:3], 3'b000});
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);

    // redirect with two responses in flight
    memLat = 3;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);
      seen = (memQ.size() == 2);
    end
    chk("redir_setup", {63'h0, seen}, 64'h1);
    cycle(1'b1, 64'h8000_0100, 1'b1, 1'b1, 1'b0, fired);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);
      seen = sInstValid;
    end
    chk("redir_seen", {63'h0, seen}, 64'h1);
    chk("redir_first_addr", sInstAddr, 64'h8000_0100);
    chk("redir_first_inst", {32'h0, sInst}, {32'h0, wordOf(64'h8000_0100)});

    // redirect colliding with a response and a pop
    memLat = 1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) cycle(1'b0, 64'h8000_0203, 1'b1, 1'b1, 1'b1, fired);
    chk("collide_fired", {63'h0, fired}, 64'h1);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);
    chk("flush_inst_valid", {63'h0, sInstValid}, 64'h0);
    chk("flush_req_valid", {63'h0, sReqValid}, 64'h1);
    chk("flush_req_addr", sReqAddr, 64'h8000_0200);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);
`ifdef IFU_BYPASS_EN
    chk("bypass_valid", {63'h0, sInstValid}, 64'h1);
    chk("bypass_addr", sInstAddr, 64'h8000_0200);
`else
    chk("regd_valid_early", {63'h0, sInstValid}, 64'h0);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);
    chk("regd_valid", {63'h0, sInstValid}, 64'h1);
    chk("regd_addr", sInstAddr, 64'h8000_0200);
`endif
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, fired);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
